// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers one request's payload, then frames header, payload and parity for the router input port.
// Latency: pl_ready rises the cycle after a valid start; header appears the cycle after the last payload beat.
// Backpressure: busy=1 holds the byte on data_out (HEADER/PAYLOAD/PARITY only); LOAD waits on pl_valid with no timeout.
//
// Ports:
//   clock, reset             single clock, synchronous active-high reset
//   start, dest, len         send request (sampled in IDLE only); dest=3 or len=0 is rejected via req_err
//   pl_valid, pl_data        payload byte stream in; pl_ready out accepts a byte
//   busy                     router flow control; the current output byte is held while high
//   data_out, pkt_valid      router input bus; pkt_valid=1 for header/payload, 0 for parity
//   ready, done, req_err     idle indication, end-of-packet pulse, rejected-request pulse
//   err_inject               only with `ROUTER_TX_ERR_INJ_EN: flips parity bit 0 of the packet it is latched with
// Parameter GAP_CYCLES (1..15): idle cycles after each parity byte before returning to IDLE.

module router_pkt_tx #(
  parameter int GAP_CYCLES = 2
) (
`ifdef ROUTER_TX_ERR_INJ_EN
  input  logic       err_inject,
`endif
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
  input  logic       pl_valid,
  input  logic [7:0] pl_data,
  output logic       pl_ready,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       ready,
  output logic       done,
  output logic       req_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    HEADER  = 3'd2,
    PAYLOAD = 3'd3,
    PARITY  = 3'd4,
    GAP     = 3'd5
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     state;
  logic [7:0] pl_buf [64];
  logic [5:0] wr_ptr;
  logic [5:0] rd_ptr;    // index of the payload byte currently on data_out
  logic [7:0] parity;
  logic [1:0] dest_q;
  logic [5:0] len_q;
  logic [3:0] gap_cnt;
  logic [7:0] parity_tx;
  logic       load_beat;

`ifdef ROUTER_TX_ERR_INJ_EN
  logic inj_q;

  always_comb begin
    parity_tx = parity ^ {7'd0, inj_q};
  end
`else
  always_comb begin
    parity_tx = parity;
  end
`endif

  // pl_ready is registered and only high in LOAD, so this is the write strobe
  always_comb begin
    load_beat = pl_valid && pl_ready;
  end

  // Payload storage needs no reset: every byte read was written by this packet
  always_ff @(posedge clock) begin
    if (load_beat) begin
      pl_buf[wr_ptr] <= pl_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      data_out  <= 8'd0;
      pkt_valid <= 1'b0;
      pl_ready  <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
      req_err   <= 1'b0;
      wr_ptr    <= 6'd0;
      rd_ptr    <= 6'd0;
      parity    <= 8'd0;
      dest_q    <= 2'd0;
      len_q     <= 6'd0;
      gap_cnt   <= 4'd0;
`ifdef ROUTER_TX_ERR_INJ_EN
      inj_q     <= 1'b0;
`endif
    end else begin
      // done and req_err are single-cycle pulses
      done    <= 1'b0;
      req_err <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (dest == 2'd3 || len == 6'd0) begin
              req_err <= 1'b1;
            end else begin
              dest_q   <= dest;
              len_q    <= len;
              parity   <= {len, dest};
              wr_ptr   <= 6'd0;
              rd_ptr   <= 6'd0;
              pl_ready <= 1'b1;
              ready    <= 1'b0;
              state    <= LOAD;
`ifdef ROUTER_TX_ERR_INJ_EN
              inj_q    <= err_inject;
`endif
            end
          end
        end

        LOAD: begin
          if (load_beat) begin
            parity <= parity ^ pl_data;
            wr_ptr <= wr_ptr + 6'd1;
            // Beat carrying byte len: header goes on the bus at this edge
            if (wr_ptr == len_q - 6'd1) begin
              pl_ready  <= 1'b0;
              data_out  <= {len_q, dest_q};
              pkt_valid <= 1'b1;
              state     <= HEADER;
            end
          end
        end

        HEADER: begin
          if (!busy) begin
            data_out <= pl_buf[rd_ptr];
            state    <= PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (!busy) begin
            if (rd_ptr == len_q - 6'd1) begin
              data_out  <= parity_tx;
              pkt_valid <= 1'b0;
              state     <= PARITY;
            end else begin
              data_out <= pl_buf[rd_ptr + 6'd1];
              rd_ptr   <= rd_ptr + 6'd1;
            end
          end
        end

        PARITY: begin
          if (!busy) begin
            data_out <= 8'd0;
            done     <= 1'b1;
            gap_cnt  <= 4'd0;
            state    <= GAP;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed vector table plus hand sequences for router_pkt_tx.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled 1 unit after the next edge.
// Expected outputs are the post-edge values of {data_out, pkt_valid, pl_ready, ready, done, req_err}.

module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] dest;
  logic [5:0] len;
  logic       pl_valid;
  logic [7:0] pl_data;
  logic       pl_ready;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       ready;
  logic       done;
  logic       req_err;
`ifdef ROUTER_TX_ERR_INJ_EN
  logic       err_inject;
`endif

  int tests = 0;
  int fails = 0;

  router_pkt_tx #(.GAP_CYCLES(2)) dut (
`ifdef ROUTER_TX_ERR_INJ_EN
    .err_inject(err_inject),
`endif
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .dest      (dest),
    .len       (len),
    .pl_valid  (pl_valid),
    .pl_data   (pl_data),
    .pl_ready  (pl_ready),
    .busy      (busy),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .ready     (ready),
    .done      (done),
    .req_err   (req_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       st;
    logic [1:0] d;
    logic [5:0] l;
    logic       plv;
    logic [7:0] pld;
    logic       bsy;
    logic [7:0] e_do;
    logic       e_pv;
    logic       e_plr;
    logic       e_rdy;
    logic       e_dn;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, input logic [1:0] d, input logic [5:0] l,
                     input logic plv, input logic [7:0] pld, input logic bsy,
                     input logic [7:0] e_do, input logic e_pv, input logic e_plr,
                     input logic e_rdy, input logic e_dn, input logic e_err);
    vec_t v;
    v.st = st; v.d = d; v.l = l; v.plv = plv; v.pld = pld; v.bsy = bsy;
    v.e_do = e_do; v.e_pv = e_pv; v.e_plr = e_plr;
    v.e_rdy = e_rdy; v.e_dn = e_dn; v.e_err = e_err;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic st, input logic [1:0] d, input logic [5:0] l,
                       input logic plv, input logic [7:0] pld, input logic bsy);
    start = st; dest = d; len = l; pl_valid = plv; pl_data = pld; busy = bsy;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [12:0] outs();
    return {data_out, pkt_valid, pl_ready, ready, done, req_err};
  endfunction

  task automatic chk(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = outs();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got do=%02h pv=%b plr=%b rdy=%b done=%b err=%b, want do=%02h pv=%b plr=%b rdy=%b done=%b err=%b",
               name, act[12:5], act[4], act[3], act[2], act[1], act[0],
               exp[12:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // {data_out, pkt_valid, pl_ready, ready, done, req_err}
  function automatic logic [12:0] o(input logic [7:0] d, input logic pv, input logic plr,
                                    input logic rdy, input logic dn, input logic err);
    return {d, pv, plr, rdy, dn, err};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- vector table ----
    // illegal requests
    add(1, 3, 2, 0, 8'h00, 0,  8'h00, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 8'h00, 0,  8'h00, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 8'h00, 0,  8'h00, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 8'h00, 0,  8'h00, 0, 0, 1, 0, 0);
    // basic frame dest=1 len=3, stray illegal starts mid-packet are ignored
    add(1, 1, 3, 0, 8'h00, 0,  8'h00, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 8'h11, 0,  8'h00, 0, 1, 0, 0, 0);
    add(1, 3, 0, 1, 8'h22, 0,  8'h00, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 8'h33, 0,  8'h0D, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0,  8'h11, 1, 0, 0, 0, 0);
    add(1, 3, 0, 0, 8'h00, 0,  8'h22, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0,  8'h33, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0,  8'h0D, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0,  8'h00, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0,  8'h00, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0,  8'h00, 0, 0, 1, 0, 0);
    // same packet with busy stalls; busy in LOAD/GAP has no effect, pl_valid gap waits
    add(1, 1, 3, 0, 8'h00, 0,  8'h00, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 8'h11, 1,  8'h00, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 8'h55, 0,  8'h00, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 8'h22, 0,  8'h00, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 8'h33, 0,  8'h0D, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 1,  8'h0D, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0,  8'h11, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0,  8'h22, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 1,  8'h22, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 1,  8'h22, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 1,  8'h22, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0,  8'h33, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0,  8'h0D, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 1,  8'h0D, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0,  8'h00, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 1,  8'h00, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0,  8'h00, 0, 0, 1, 0, 0);

    // ---- reset ----
    reset = 1'b1;
`ifdef ROUTER_TX_ERR_INJ_EN
    err_inject = 1'b0;
`endif
    drive(0, 0, 0, 0, 8'h00, 0);
    tick();
    tick();
    chk("reset_state", o(8'h00, 0, 0, 1, 0, 0));
    reset = 1'b0;

    // ---- table ----
    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].d, tbl[i].l, tbl[i].plv, tbl[i].pld, tbl[i].bsy);
      tick();
      chk($sformatf("vec%0d", i),
          o(tbl[i].e_do, tbl[i].e_pv, tbl[i].e_plr, tbl[i].e_rdy, tbl[i].e_dn, tbl[i].e_err));
    end

    // ---- max length: dest=2 len=63 payload 0x00..0x3E ----
    drive(1, 2, 63, 0, 8'h00, 0);
    tick();
    chk("max_load", o(8'h00, 0, 1, 0, 0, 0));
    for (int i = 0; i < 63; i++) begin
      drive(0, 0, 0, 1, 8'(i), 0);
      tick();
    end
    chk("max_header", o(8'hFE, 1, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 63; i++) begin
      tick();
      chk($sformatf("max_b%0d", i), o(8'(i), 1, 0, 0, 0, 0));
      if (i == 30) begin
        busy = 1'b1;
        tick();
        chk("max_hold", o(8'd30, 1, 0, 0, 0, 0));
        busy = 1'b0;
      end
    end
    tick();
    chk("max_parity", o(8'hC1, 0, 0, 0, 0, 0));
    tick();
    chk("max_done", o(8'h00, 0, 0, 0, 1, 0));
    tick();
    tick();
    chk("max_ready", o(8'h00, 0, 0, 1, 0, 0));

    // ---- reset in PAYLOAD after 2 of 5 bytes, then a 1-byte packet ----
    drive(1, 0, 5, 0, 8'h00, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 1, 8'(8'hA1 + k), 0);
      tick();
    end
    chk("rst_header", o(8'h14, 1, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 8'h00, 0);
    tick();
    tick();
    tick();
    chk("rst_pre", o(8'hA3, 1, 0, 0, 0, 0));
    reset = 1'b1;
    tick();
    chk("rst_mid", o(8'h00, 0, 0, 1, 0, 0));
    reset = 1'b0;
    drive(1, 2, 1, 0, 8'h00, 0);
    tick();
    chk("one_load", o(8'h00, 0, 1, 0, 0, 0));
    drive(0, 0, 0, 1, 8'h5A, 0);
    tick();
    chk("one_header", o(8'h06, 1, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 8'h00, 0);
    tick();
    chk("one_byte", o(8'h5A, 1, 0, 0, 0, 0));
    tick();
    chk("one_parity", o(8'h5C, 0, 0, 0, 0, 0));
    tick();
    chk("one_done", o(8'h00, 0, 0, 0, 1, 0));
    tick();
    tick();
    chk("one_ready", o(8'h00, 0, 0, 1, 0, 0));

`ifdef ROUTER_TX_ERR_INJ_EN
    // ---- parity error injection on the basic frame ----
    err_inject = 1'b1;
    drive(1, 1, 3, 0, 8'h00, 0);
    tick();
    err_inject = 1'b0;
    drive(0, 0, 0, 1, 8'h11, 0);
    tick();
    drive(0, 0, 0, 1, 8'h22, 0);
    tick();
    drive(0, 0, 0, 1, 8'h33, 0);
    tick();
    chk("inj_header", o(8'h0D, 1, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 8'h00, 0);
    tick();
    chk("inj_b0", o(8'h11, 1, 0, 0, 0, 0));
    tick();
    chk("inj_b1", o(8'h22, 1, 0, 0, 0, 0));
    tick();
    chk("inj_b2", o(8'h33, 1, 0, 0, 0, 0));
    tick();
    chk("inj_parity", o(8'h0C, 0, 0, 0, 0, 0));
    tick();
    chk("inj_done", o(8'h00, 0, 0, 0, 1, 0));
    tick();
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
